// File: rtl/muldiv_pkg.sv
// +--------------------------------------------------------------------+
// | muldiv_pkg -- shared opcodes, FSM states and helpers for muldiv_seq |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  // {a is signed, b is signed} for a given opcode
  function automatic logic [1:0] op_signs(input logic [2:0] f3);
    logic [1:0] s;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: s = 2'b11;
      F3_MULHSU:               s = 2'b10;
      F3_MUL, F3_MULHU,
      F3_DIVU, F3_REMU:        s = 2'b00;
      default:                 s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq_if.sv
// +--------------------------------------------------------------------+
// | muldiv_seq_if -- request/response bundle of the mul/div sequencer   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_zero;

  modport master (
    output start, flush, funct3, a, b,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, flush, funct3, a, b,
    output busy, done, result, div_zero
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_seq_core.sv
// +--------------------------------------------------------------------+
// | muldiv_core -- one radix-2 shift-add / restoring-subtract iteration |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   w_mul_sum;
  logic [2*WIDTH:0] w_div_sh;
  logic [WIDTH:0]   w_div_diff;

  always_comb begin
    w_mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Shifted remainder needs one extra bit before the trial subtract
    w_div_sh   = {acc_i, 1'b0};
    w_div_diff = w_div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_i};
    if (div_mode_i) begin
      if (w_div_diff[WIDTH]) begin
        acc_o = w_div_sh[2*WIDTH-1:0];
      end else begin
        acc_o = {w_div_diff[WIDTH-1:0], w_div_sh[WIDTH-1:1], 1'b1};
      end
    end else begin
      acc_o = {w_mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// +--------------------------------------------------------------------+
// | muldiv_seq -- iterative RV32M multiply/divide sequencer             |
// | Optional MULDIV_EARLY_OUT_EN: special cases bypass CALC. Rev 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam int             CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           op_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 neg_q;
  logic                 dz_pend_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     result_q;
  logic                 div_zero_q;

  logic [1:0]           w_sgn;
  logic                 w_sa;
  logic                 w_sb;
  logic                 w_is_div;
  logic                 w_b_zero;
  logic                 w_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_opnd_init;
  logic [2*WIDTH-1:0]   w_acc_init;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_div_sel;
  logic [WIDTH-1:0]     w_div_res;
  logic [WIDTH-1:0]     result_d;

  always_comb begin
    w_sgn       = op_signs(bus.funct3);
    w_sa        = w_sgn[1] & bus.a[WIDTH-1];
    w_sb        = w_sgn[0] & bus.b[WIDTH-1];
    w_is_div    = bus.funct3[2];
    w_b_zero    = (bus.b == '0);
    w_a_mag     = w_sa ? -bus.a : bus.a;
    w_b_mag     = w_sb ? -bus.b : bus.b;
    // Division by zero must keep the all-ones quotient un-negated
    case (bus.funct3)
      F3_REM, F3_REMU: w_neg = w_sa;
      F3_DIV, F3_DIVU: w_neg = (w_sa ^ w_sb) & ~w_b_zero;
      default:         w_neg = w_sa ^ w_sb;
    endcase
    w_acc_init  = w_is_div ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
    w_opnd_init = w_is_div ? w_b_mag : w_a_mag;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic               w_skip;
  logic [2*WIDTH-1:0] w_acc_skip;

  // Preload the accumulator with what CALC would have produced
  always_comb begin
    w_skip     = 1'b0;
    w_acc_skip = '0;
    if (w_is_div) begin
      if (w_b_zero) begin
        w_skip     = 1'b1;
        w_acc_skip = {w_a_mag, {WIDTH{1'b1}}};
      end else if (w_sgn[1] && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1)) begin
        w_skip     = 1'b1;
        w_acc_skip = {{WIDTH{1'b0}}, w_a_mag};
      end
    end else if ((bus.a == '0) || w_b_zero) begin
      w_skip = 1'b1;
    end
  end
`endif

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .div_mode_i (op_q[2]),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_o      (w_acc_step)
  );

  always_comb begin
    w_prod    = neg_q ? -acc_q : acc_q;
    w_div_sel = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    w_div_res = neg_q ? -w_div_sel : w_div_sel;
    if (op_q[2]) begin
      result_d = w_div_res;
    end else if (op_q == F3_MUL) begin
      result_d = w_prod[WIDTH-1:0];
    end else begin
      result_d = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_q      <= 1'b0;
      dz_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start && !bus.flush) begin
              op_q      <= bus.funct3;
              neg_q     <= w_neg;
              dz_pend_q <= w_is_div & w_b_zero;
              cnt_q     <= '0;
              acc_q     <= w_acc_init;
              opnd_q    <= w_opnd_init;
              busy_q    <= 1'b1;
              state_q   <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
              if (w_skip) begin
                acc_q   <= w_acc_skip;
                state_q <= S_FIX;
              end
`endif
            end
          end
          S_CALC: begin
            acc_q <= w_acc_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= S_FIX;
            end
          end
          S_FIX: begin
            result_q   <= result_d;
            div_zero_q <= dz_pend_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// +--------------------------------------------------------------------+
// | tb_muldiv_seq -- scoreboard bench for muldiv_seq (RV32M reference)  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_seq;

  localparam int W = 32;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          acc_cyc;
    int          lat;
    int          bsy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   busy_cnt = 0;
  logic [31:0] last_res = '0;
  logic        last_dz = 1'b0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sbv = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub;              return p[31:0];  end
      3'd1: begin p = 64'(sa * sbv);        return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub;              return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbv);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sbv);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && !f3[0];
    if (f3[2] && ((b == 0) || ovf)) return 1;
    if (!f3[2] && ((a == 0) || (b == 0))) return 1;
`endif
    return W + 1;
  endfunction

  // Scoreboard: accept detection pushes, done pops; all sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      last_res = '0;
      last_dz  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("div_zero", {31'b0, bus.div_zero}, {31'b0, e.dz});
          chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.bsy));
          last_res = e.res;
          last_dz  = e.dz;
        end
      end else if (sb.size() > 0 && (cyc - sb[0].acc_cyc) > sb[0].lat + 4) begin
        chk("done_timeout", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      if (bus.flush && bus.busy && sb.size() > 0) void'(sb.pop_back());
      if (bus.start && !bus.flush && !bus.busy && !bus.done) begin
        e.res     = ref_res(bus.funct3, bus.a, bus.b);
        e.dz      = bus.funct3[2] && (bus.b == 0);
        e.acc_cyc = cyc + 1;
        e.lat     = ref_lat(bus.funct3, bus.a, bus.b);
        e.bsy     = e.lat;
        sb.push_back(e);
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((bus.busy || bus.done) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 80) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 80) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    bus.start = 1'b1; bus.funct3 = f3; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    wait_done();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_div_zero", {31'b0, bus.div_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd5, 32'h1234, 32'd0);
    issue(3'd6, 32'h1234, 32'd0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd0, 32'd0, 32'd12345);

    // Abort in CALC cycle 10; result must hold, next op runs normally
    wait_idle();
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk("flush_result_held", bus.result, last_res);
    chk("flush_dz_held", {31'b0, bus.div_zero}, {31'b0, last_dz});
    issue(3'd7, 32'd1000, 32'd3);

    // Asynchronous reset in the middle of CALC
    wait_idle();
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.done}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // start held high: one accept per IDLE visit, three in this window
    d0 = n_done;
    bus.start = 1'b1; bus.funct3 = 3'd3; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
    repeat (3 * W + 8) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    wait_idle();
    @(posedge clk); #1;
    chk("held_start_ops", 32'(n_done - d0), 32'd3);

    // Random traffic with stray starts while busy and occasional flushes
    repeat (3000) begin
      @(posedge clk); #1;
      bus.start  = ($urandom % 3) == 0;
      bus.flush  = ($urandom % 50) == 0;
      bus.funct3 = 3'($urandom);
      bus.a      = pick();
      bus.b      = pick();
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
